// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, ordered {a..g}) and the scan-capture state encoding.
// Display drivers and the capture monitor both import this package.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_ERR   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // True when exactly one active-low digit enable is asserted.
  function automatic logic one_low(input logic [7:0] en);
    return $countones(~en) == 1;
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scanned 7-segment bus plus the decoded-frame report; master = display side, slave = capture monitor.
// No backpressure: the bus is free-running and frames are reported with a single-cycle pulse.
interface seg_scan_capture_if;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg;
  logic        led_dp;
  logic [31:0] digit_bcd;
  logic [7:0]  digit_blank;
  logic [7:0]  digit_err;
  logic [7:0]  dp_mask;
  logic        frame_valid;
  logic        fault;

  modport master (
    output led_en, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp,
    input  digit_bcd, digit_blank, digit_err, dp_mask, frame_valid, fault
  );

  modport slave (
    input  led_en, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp,
    output digit_bcd, digit_blank, digit_err, dp_mask, frame_valid, fault
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational active-low {a..g} segment pattern to BCD, flagging blank and undecodable patterns.
// Zero latency, no flow control.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  always_comb begin
    bcd   = BCD_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        bcd   = 4'd0;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitors a scanned 8-digit 7-segment bus, captures each settled digit and publishes full frames.
// Latency: 1 input register + SETTLE_CYCLES equal samples + 1 publish cycle; no backpressure.
module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int IDLE_TIMEOUT  = 1024,
  parameter int TO_W          = 11
) (
  input logic clk,
  input logic rst,
  seg_scan_capture_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]   STAB_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]   STAB_HIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] IDLE_MAX = TO_W'(IDLE_TIMEOUT);

  logic [7:0]      en_r, en_p;
  logic [6:0]      seg_r, seg_p;
  logic            dp_r, dp_p;
  logic [3:0]      dec_bcd;
  logic            dec_blank, dec_err;
  state_t          state;
  logic [SW-1:0]   stab_cnt, stab_nxt;
  logic [TO_W-1:0] idle_cnt;
  logic [7:0]      mask, mask_hit;
  logic            same, en_ff, en_one, en_multi, capture, mask_full;
  logic [31:0]     stg_bcd, stg_bcd_nxt, bcd_q;
  logic [7:0]      stg_blank, stg_blank_nxt, blank_q;
  logic [7:0]      stg_err, stg_err_nxt, err_q;
  logic [7:0]      stg_dp, stg_dp_nxt, dp_q;
  logic            frame_valid_q, fault_q;

  // Current sample and the one before it; stability is judged on the registered pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r  <= 8'hFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
      en_p  <= 8'hFF;
      seg_p <= SEG_BLANK;
      dp_p  <= 1'b1;
    end else begin
      en_r  <= bus.led_en;
      seg_r <= {bus.led_ca, bus.led_cb, bus.led_cc, bus.led_cd,
                bus.led_ce, bus.led_cf, bus.led_cg};
      dp_r  <= bus.led_dp;
      en_p  <= en_r;
      seg_p <= seg_r;
      dp_p  <= dp_r;
    end
  end

  seg7_decode u_dec (
    .seg   (seg_r),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .err   (dec_err)
  );

  assign same     = {en_r, seg_r, dp_r} == {en_p, seg_p, dp_p};
  assign en_ff    = &en_r;
  assign en_one   = one_low(en_r);
  assign en_multi = !en_ff && !en_one;

  // Saturation at SETTLE_CYCLES keeps the HIT value from recurring within one dwell.
  always_comb begin
    stab_nxt = '0;
    if (same) stab_nxt = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
  end

  assign capture = (state == S_SCAN) && en_one && (stab_nxt == STAB_HIT);

  always_comb begin
    stg_bcd_nxt   = stg_bcd;
    stg_blank_nxt = stg_blank;
    stg_err_nxt   = stg_err;
    stg_dp_nxt    = stg_dp;
    mask_hit      = 8'h00;
    if (capture) begin
      mask_hit = ~en_r;
      for (int i = 0; i < 8; i++) begin
        if (!en_r[i]) begin
          stg_bcd_nxt[i*4 +: 4] = dec_bcd;
          stg_blank_nxt[i]      = dec_blank;
          stg_err_nxt[i]        = dec_err;
          stg_dp_nxt[i]         = !dp_r;
        end
      end
    end
  end

  assign mask_full = capture && ((mask | mask_hit) == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      stab_cnt      <= '0;
      idle_cnt      <= '0;
      mask          <= 8'h00;
      stg_bcd       <= 32'h0;
      stg_blank     <= 8'h00;
      stg_err       <= 8'h00;
      stg_dp        <= 8'h00;
      bcd_q         <= 32'h0;
      blank_q       <= 8'h00;
      err_q         <= 8'h00;
      dp_q          <= 8'h00;
      frame_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      stab_cnt      <= stab_nxt;
      stg_bcd       <= stg_bcd_nxt;
      stg_blank     <= stg_blank_nxt;
      stg_err       <= stg_err_nxt;
      stg_dp        <= stg_dp_nxt;
      frame_valid_q <= mask_full;
      mask          <= mask_full ? 8'h00 : (mask | mask_hit);
      if (mask_full) begin
        bcd_q   <= stg_bcd_nxt;
        blank_q <= stg_blank_nxt;
        err_q   <= stg_err_nxt;
        dp_q    <= stg_dp_nxt;
      end
      case (state)
        S_IDLE: begin
          if (en_multi) begin
            state    <= S_FAULT;
            fault_q  <= 1'b1;
            mask     <= 8'h00;
            idle_cnt <= '0;
          end else if (en_one) begin
            state    <= S_SCAN;
            idle_cnt <= '0;
          end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
          end else begin
            mask <= 8'h00;
          end
        end
        S_SCAN: begin
          if (en_multi) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
            mask    <= 8'h00;
          end else if (en_ff) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
          end
        end
        default: begin
          mask <= 8'h00;
          if (en_one) begin
            state   <= S_SCAN;
            fault_q <= 1'b0;
          end else if (en_ff) begin
            state    <= S_IDLE;
            fault_q  <= 1'b0;
            idle_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign bus.digit_bcd   = bcd_q;
  assign bus.digit_blank = blank_q;
  assign bus.digit_err   = err_q;
  assign bus.dp_mask     = dp_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Drives dwell-based scan stimulus into seg_scan_capture and compares published frames and fault
// against a per-dwell reference model of the capture rules.
module tb_seg_scan_capture;

  localparam int SETTLE = 2;
  localparam int TMO    = 1024;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  blank;
    logic [7:0]  err;
    logic [7:0]  dp;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_capture_if bus ();

  seg_scan_capture #(
    .SETTLE_CYCLES (SETTLE),
    .IDLE_TIMEOUT  (TMO),
    .TO_W          (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
  int t1_dig [8] = '{3, 1, 5, 0, 0, 2, 0, 1};

  int n_chk  = 0;
  int n_pass = 0;
  int frames = 0;

  // Reference model state: mode 0 idle, 1 scanning, 2 fault.
  int          m_mode = 0;
  logic [7:0]  m_mask = 8'h00;
  logic [31:0] m_bcd  = 32'h0;
  logic [7:0]  m_blank = 8'h00, m_err = 8'h00, m_dp = 8'h00;
  frame_t      exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [6:0] pick_code(input int top);
    int k;
    logic [6:0] c;
    logic hit;
    k = $urandom_range(0, top);
    if (k < 10) return seg_tab[k];
    if (k == 10) return 7'h7F;
    do begin
      c   = 7'($urandom);
      hit = (c == 7'h7F);
      for (int d = 0; d < 10; d++) if (c == seg_tab[d]) hit = 1'b1;
    end while (hit);
    return c;
  endfunction

  task automatic model_capture(input int slot, input logic [6:0] seg, input logic dp);
    logic [3:0] nib;
    logic bl, er;
    nib = 4'hF; bl = 1'b0; er = 1'b1;
    for (int d = 0; d < 10; d++) begin
      if (seg == seg_tab[d]) begin
        nib = d[3:0];
        er  = 1'b0;
      end
    end
    if (seg == 7'h7F) begin
      nib = 4'h0; bl = 1'b1; er = 1'b0;
    end
    m_bcd[slot*4 +: 4] = nib;
    m_blank[slot] = bl;
    m_err[slot]   = er;
    m_dp[slot]    = !dp;
    m_mask[slot]  = 1'b1;
    if (m_mask == 8'hFF) begin
      exp_q.push_back('{m_bcd, m_blank, m_err, m_dp});
      m_mask = 8'h00;
    end
  endtask

  // One dwell: the model is advanced first so expected frames are queued before the DUT pulses.
  task automatic apply(input logic [7:0] en, input logic [6:0] seg, input logic dp, input int dwell);
    int zeros, slot;
    zeros = 0; slot = 0;
    for (int i = 0; i < 8; i++) if (!en[i]) begin zeros++; slot = i; end
    if (zeros == 0) begin
      if (dwell >= TMO + 2) m_mask = 8'h00;
      m_mode = 0;
    end else if (zeros > 1) begin
      m_mode = 2;
      m_mask = 8'h00;
    end else begin
      m_mode = 1;
      if (dwell >= SETTLE) model_capture(slot, seg, dp);
    end
    bus.led_en = en;
    {bus.led_ca, bus.led_cb, bus.led_cc, bus.led_cd, bus.led_ce, bus.led_cf, bus.led_cg} = seg;
    bus.led_dp = dp;
    repeat (dwell) @(negedge clk);
    if (dwell >= 2) chk("fault", {31'd0, bus.fault}, {31'd0, m_mode == 2});
  endtask

  task automatic put(input int slot, input logic [6:0] code, input logic dp, input int dwell);
    apply(~(8'b1 << slot), code, dp, dwell);
  endtask

  task automatic full_rot(input int dwell);
    for (int s = 0; s < 8; s++) put(s, pick_code(11), 1'($urandom), dwell);
  endtask

  task automatic idle(input int n);
    apply(8'hFF, 7'h7F, 1'b1, n);
  endtask

  task automatic flush();
    apply(8'hFC, 7'h7F, 1'b1, 3);
    idle(2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bcd"},   bus.digit_bcd, 32'h0);
    chk({tag, "_blank"}, {24'd0, bus.digit_blank}, 32'h0);
    chk({tag, "_err"},   {24'd0, bus.digit_err}, 32'h0);
    chk({tag, "_dp"},    {24'd0, bus.dp_mask}, 32'h0);
    chk({tag, "_fv"},    {31'd0, bus.frame_valid}, 32'h0);
    chk({tag, "_fault"}, {31'd0, bus.fault}, 32'h0);
  endtask

  logic fv_d = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    if (bus.frame_valid) begin
      frames++;
      chk("fv_width", {31'd0, fv_d}, 32'h0);
      chk("frame_expected", {31'd0, exp_q.size() > 0}, 32'h1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        chk("frame_bcd",   bus.digit_bcd, f.bcd);
        chk("frame_blank", {24'd0, bus.digit_blank}, {24'd0, f.blank});
        chk("frame_err",   {24'd0, bus.digit_err}, {24'd0, f.err});
        chk("frame_dp",    {24'd0, bus.dp_mask}, {24'd0, f.dp});
      end
    end
    fv_d = bus.frame_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, a, b;
    logic [7:0] en;
    logic [6:0] sg;
    logic dpv;
    logic [15:0] last;

    rst = 1'b1;
    bus.led_en = 8'hFF;
    {bus.led_ca, bus.led_cb, bus.led_cc, bus.led_cd, bus.led_ce, bus.led_cf, bus.led_cg} = 7'h7F;
    bus.led_dp = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Fixed digits, long dwell.
    f0 = frames;
    for (int s = 0; s < 8; s++) put(s, seg_tab[t1_dig[s]], 1'b1, 6);
    idle(4);
    chk("t1_frames", frames - f0, 1);
    chk("t1_bcd", bus.digit_bcd, 32'h10200513);
    chk("t1_blank", {24'd0, bus.digit_blank}, 32'h0);
    chk("t1_err", {24'd0, bus.digit_err}, 32'h0);

    // Short dwell on slot 3 is not captured.
    flush();
    f0 = frames;
    for (int s = 0; s < 8; s++) put(s, pick_code(9), 1'($urandom), (s == 3) ? 1 : 2);
    idle(4);
    chk("t2_no_frame", frames - f0, 0);
    full_rot(2);
    idle(4);
    chk("t2_frame", frames - f0, 1);

    // Blank on slot 4, undecodable pattern on slot 2.
    flush();
    f0 = frames;
    for (int s = 0; s < 8; s++) begin
      if (s == 4)      put(s, 7'b1111111, 1'b1, 3);
      else if (s == 2) put(s, 7'b1111110, 1'b1, 3);
      else             put(s, pick_code(9), 1'b1, 3);
    end
    idle(4);
    chk("t3_frames", frames - f0, 1);
    chk("t3_blank", {24'd0, bus.digit_blank}, 32'h10);
    chk("t3_err", {24'd0, bus.digit_err}, 32'h04);
    chk("t3_nib2", {28'd0, bus.digit_bcd[11:8]}, 32'hF);

    // Multi-low enable mid-frame discards the partial frame.
    flush();
    f0 = frames;
    for (int s = 0; s < 4; s++) put(s, pick_code(11), 1'($urandom), 3);
    apply(8'hFC, 7'h7F, 1'b1, 3);
    chk("t4_fault_hi", {31'd0, bus.fault}, 32'h1);
    full_rot(3);
    idle(4);
    chk("t4_fault_lo", {31'd0, bus.fault}, 32'h0);
    chk("t4_frames", frames - f0, 1);

    // Idle timeout discards captured slots.
    flush();
    f0 = frames;
    for (int s = 0; s < 5; s++) put(s, pick_code(11), 1'($urandom), 3);
    idle(TMO + 8);
    for (int s = 5; s < 8; s++) put(s, pick_code(11), 1'($urandom), 3);
    idle(4);
    chk("t5_no_frame", frames - f0, 0);
    full_rot(3);
    idle(4);
    chk("t5_frame", frames - f0, 1);

    // Reset in the middle of the second frame.
    flush();
    full_rot(3);
    for (int s = 0; s < 4; s++) put(s, pick_code(11), 1'($urandom), 3);
    rst = 1'b1;
    bus.led_en = 8'hFF;
    {bus.led_ca, bus.led_cb, bus.led_cc, bus.led_cd, bus.led_ce, bus.led_cf, bus.led_cg} = 7'h7F;
    bus.led_dp = 1'b1;
    @(negedge clk);
    check_zero("t6_rst");
    rst = 1'b0;
    m_mode = 0;
    m_mask = 8'h00;
    f0 = frames;
    full_rot(3);
    idle(4);
    chk("t6_frame", frames - f0, 1);

    // Random dwells, slots, patterns, faults and idle gaps.
    last = 16'h0;
    for (int k = 0; k < 80; k++) begin
      a = $urandom_range(0, 9);
      if (a == 0) begin
        a  = $urandom_range(0, 7);
        b  = (a + $urandom_range(1, 7)) % 8;
        en = ~((8'b1 << a) | (8'b1 << b));
      end else if (a == 1) begin
        en = 8'hFF;
      end else begin
        en = ~(8'b1 << $urandom_range(0, 7));
      end
      sg  = pick_code(11);
      dpv = 1'($urandom);
      if ({en, sg, dpv} == last) dpv = ~dpv;
      last = {en, sg, dpv};
      apply(en, sg, dpv, $urandom_range(1, 5));
    end
    flush();
    idle(4);
    chk("frames_all_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
Receive-side monitor for the multiplexed 8-digit 7-segment bus driven by the display controllers: active-low digit enables, active-low segments ordered a..g, and a decimal point.
- Watches the scanned bus, waits for each digit's segment pattern to settle, and decodes it back to BCD.
- Assembles a full 8-digit frame and reports it with a one-cycle valid pulse.
- Used as a loopback checker on board and as a scoreboard front-end in simulation.

Parameters:
SETTLE_CYCLES, 2, consecutive identical samples (same led_en and segments) required before a digit is captured; must be ≥1.
IDLE_TIMEOUT, 1024, cycles of led_en==8'hFF after which the partial frame is discarded.
TO_W, 11, width of the idle counter; must satisfy 2^TO_W > IDLE_TIMEOUT.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
led_en  in  8  digit enables, active-low, one-hot-low when valid
led_ca..led_cg  in  1 each  segments a..g, active-low
led_dp  in  1  decimal point, active-low
digit_bcd  out  32  decoded frame; nibble i = digit of led_en[i] (digit 7 in [31:28])
digit_blank  out  8  bit i = slot i captured as all-segments-off
digit_err  out  8  bit i = slot i captured with an undecodable pattern
dp_mask  out  8  bit i = decimal point of slot i lit
frame_valid  out  1  one-cycle pulse when a new frame is published
fault  out  1  led_en had more than one bit low

Behaviour:
- Reset is synchronous, active-high, one clock, and dominates every other input. Reset values:
  - digit_bcd = 0, digit_blank = 0, digit_err = 0, dp_mask = 0.
  - frame_valid = 0, fault = 0.
  - capture mask, stability counter and idle counter = 0; state = S_IDLE.
- Input stage: led_en, the segments {a..g} and dp are registered once. All logic below uses the registered copies, whose previous-cycle values are held for comparison.
- Segment decode, seg = {a,b,c,d,e,f,g}:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9
  - 1111111 → blank, nibble 0, blank bit set.
  - Any other pattern → nibble 4'hF, err bit set.
- Stability:
  - If the registered {led_en, seg, dp} equals the previous registered value, stab_cnt increments, saturating at SETTLE_CYCLES; otherwise stab_cnt is cleared to 0.
  - A capture fires on the cycle stab_cnt reaches SETTLE_CYCLES-1 from below. A capture fires at most once per dwell.
- State machine:
  - S_IDLE: led_en==FF. Idle counter runs, saturating at IDLE_TIMEOUT; when it equals IDLE_TIMEOUT, the capture mask clears. A one-hot-low led_en → S_SCAN; a multi-low led_en → S_FAULT.
  - S_SCAN: on capture, write slot i's staging nibble, blank, err and dp bits, and set mask[i]. Recapturing an already-set slot overwrites it. led_en==FF → S_IDLE, idle counter cleared. Multi-low → S_FAULT.
  - S_FAULT: fault=1, mask cleared, no captures. One-hot-low → S_SCAN with fault=0 on the same edge; FF → S_IDLE with fault=0.
- Frame publish:
  - When a capture makes the mask 8'hFF, the next cycle copies staging into digit_bcd, digit_blank, digit_err and dp_mask, pulses frame_valid for exactly 1 cycle, and clears the mask.
  - Latency: input change → registered 1 cycle → capture after SETTLE_CYCLES equal samples → outputs 1 cycle later.
  - Published outputs hold until the next frame or reset.
- Simultaneous events: a capture and an FF/multi-low on the same sampled cycle cannot occur, because stability requires an unchanged led_en.
- Mid-operation reset: the partial frame is lost and the published outputs return to 0.

Decomposition:
- Shared package seg7_pkg: the 10 segment codes (SEG_0..SEG_9), SEG_BLANK=7'h7F, BCD_ERR=4'hF, and the state encoding S_IDLE/S_SCAN/S_FAULT. The display drivers use the same segment constants.
- One sub-module, seg7_decode: combinational seg→{bcd, blank, err}, instantiated once on the registered segments.

Test Plan:
1. Reset, then rotate led_en FE→FD→…→7F with digits 3,1,5,0,0,2,0,1 (slot 0..7), 6-cycle dwell each → one frame_valid pulse, digit_bcd=32'h10200513, digit_blank=0, digit_err=0.
2. SETTLE_CYCLES=2 with a 1-cycle dwell on one slot → that slot is not captured and no frame_valid occurs; raise the dwell to 2 → frame published.
3. Slot 4 driven 1111111 and slot 2 driven 1111110 in an otherwise valid frame → digit_blank=8'h10, digit_err=8'h04, nibble 2=4'hF.
4. led_en=8'hFC for 3 cycles mid-frame → fault=1 and mask cleared; a following full rotation → fault=0, frame published with the new values only.
5. Capture 5 slots, then hold led_en=FF for IDLE_TIMEOUT cycles, then capture the remaining 3 slots → no frame_valid; a subsequent full rotation → frame_valid.
6. Assert rst in the middle of the second frame → all outputs 0 on the next edge; a full rotation after release publishes correctly.
